f_gray_ptr_sync: RTL and testbench

//   Parametrised multi-stage synchroniser for Gray-coded FIFO pointers entering the CLK domain.

---
 rtl/f_gray_ptr_sync.sv | 52 +++++
 tb/tb_f_gray_ptr_sync.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/f_gray_ptr_sync.sv
// f_gray_ptr_sync: multi-stage Gray pointer synchroniser with registered binary decode,
// update strobe and a checker that flags steps changing more than one bit.
module f_gray_ptr_sync #(
    parameter int BUS_WIDTH  = 4,
    parameter int NUM_STAGES = 2,
    parameter bit CHECK_EN   = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_gray,
    input  logic                 clr_err,
    output logic [BUS_WIDTH-1:0] sync_gray,
    output logic [BUS_WIDTH-1:0] sync_bin,
    output logic                 sync_update,
    output logic                 gray_err,
    output logic                 err_sticky,
    output logic [7:0]           err_count
);
    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("f_gray_ptr_sync: NUM_STAGES must be >= 2");
    end
    logic [BUS_WIDTH-1:0] s [NUM_STAGES];
    logic [BUS_WIDTH-1:0] last_gray, diff, bin_next;
    logic                 err_next;
    assign sync_gray = s[NUM_STAGES-1];
    // diff & (diff-1) is non-zero exactly when more than one bit of diff is set
    always_comb begin
        diff     = sync_gray ^ last_gray;
        err_next = CHECK_EN && ((diff & (diff - BUS_WIDTH'(1))) != '0);
        for (int i = 0; i < BUS_WIDTH; i++) bin_next[i] = ^(sync_gray >> i);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NUM_STAGES; k++) s[k] <= '0;
            last_gray   <= '0;
            sync_bin    <= '0;
            sync_update <= 1'b0;
            gray_err    <= 1'b0;
            err_sticky  <= 1'b0;
            err_count   <= '0;
        end else begin
            s[0] <= unsync_gray;
            for (int k = 1; k < NUM_STAGES; k++) s[k] <= s[k-1];
            last_gray   <= sync_gray;
            sync_bin    <= bin_next;
            sync_update <= |diff;
            gray_err    <= err_next;
            err_sticky  <= clr_err ? 1'b0 : (err_sticky | err_next);
            err_count   <= clr_err ? 8'd0 : (err_next && err_count != 8'd255) ? err_count + 8'd1 : err_count;
        end
    end
endmodule

// File: tb/tb_f_gray_ptr_sync.sv
// tb_f_gray_ptr_sync: directed checks of the Gray pointer synchroniser, default build
// plus a 3-stage build with the checker disabled.
module tb_f_gray_ptr_sync;
    logic       CLK, RST, clr_err;
    logic [3:0] unsync_gray;
    logic [3:0] sync_gray, sync_bin, sync_gray3, sync_bin3;
    logic       sync_update, gray_err, err_sticky;
    logic       sync_update3, gray_err3, err_sticky3;
    logic [7:0] err_count, err_count3;
    int         checks = 0, errors = 0, ups, errs;
    logic [3:0] v;

    f_gray_ptr_sync #(.BUS_WIDTH(4), .NUM_STAGES(2), .CHECK_EN(1)) dut (
        .CLK(CLK), .RST(RST), .unsync_gray(unsync_gray), .clr_err(clr_err),
        .sync_gray(sync_gray), .sync_bin(sync_bin), .sync_update(sync_update),
        .gray_err(gray_err), .err_sticky(err_sticky), .err_count(err_count)
    );
    f_gray_ptr_sync #(.BUS_WIDTH(4), .NUM_STAGES(3), .CHECK_EN(0)) dut3 (
        .CLK(CLK), .RST(RST), .unsync_gray(unsync_gray), .clr_err(clr_err),
        .sync_gray(sync_gray3), .sync_bin(sync_bin3), .sync_update(sync_update3),
        .gray_err(gray_err3), .err_sticky(err_sticky3), .err_count(err_count3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gray"}, 32'(sync_gray), 0);
        chk({tag, "_bin"}, 32'(sync_bin), 0);
        chk({tag, "_upd"}, 32'(sync_update), 0);
        chk({tag, "_err"}, 32'(gray_err), 0);
        chk({tag, "_sticky"}, 32'(err_sticky), 0);
        chk({tag, "_count"}, 32'(err_count), 0);
    endtask

    initial begin
        RST = 1'b1; clr_err = 1'b0; unsync_gray = 4'b1010;
        repeat (3) step();
        chk_zero("rst");
        chk("rst_gray3", 32'(sync_gray3), 0);
        // single-bit first step: sync_gray after 2 edges, decode and strobe after 3
        RST = 1'b0; unsync_gray = 4'b0001;
        step();
        step();
        chk("t1_gray_e2", 32'(sync_gray), 1);
        chk("t1_upd_e2", 32'(sync_update), 0);
        step();
        chk("t1_bin_e3", 32'(sync_bin), 1);
        chk("t1_upd_e3", 32'(sync_update), 1);
        step();
        chk("t1_upd_e4", 32'(sync_update), 0);
        // full Gray sequence 0..15 then wrap to 0
        ups = 0; errs = 0;
        for (int b = 0; b <= 16; b++) begin
            v = 4'(b);
            unsync_gray = v ^ (v >> 1);
            repeat (4) begin
                step();
                ups += int'(sync_update);
                errs += int'(gray_err);
            end
            chk("t2_bin", 32'(sync_bin), 32'(v));
        end
        chk("t2_ups", ups, 17);
        chk("t2_errs", errs, 0);
        chk("t2_count", 32'(err_count), 0);
        // two-bit jump 0000 -> 0011
        unsync_gray = 4'b0011;
        step();
        step();
        step();
        chk("t3_err", 32'(gray_err), 1);
        chk("t3_upd", 32'(sync_update), 1);
        chk("t3_bin", 32'(sync_bin), 2);
        step();
        chk("t3_err_after", 32'(gray_err), 0);
        chk("t3_sticky", 32'(err_sticky), 1);
        chk("t3_count", 32'(err_count), 1);
        // toggle 0000/0011 every cycle: every step is a two-bit error
        for (int i = 0; i < 265; i++) begin
            unsync_gray = i[0] ? 4'b0011 : 4'b0000;
            step();
        end
        chk("t4_sat", 32'(err_count), 255);
        chk("t4_sticky", 32'(err_sticky), 1);
        unsync_gray = 4'b0011; clr_err = 1'b1;
        step();
        chk("t4_clr_err", 32'(gray_err), 1);
        chk("t4_clr_count", 32'(err_count), 0);
        chk("t4_clr_sticky", 32'(err_sticky), 0);
        clr_err = 1'b0;
        repeat (4) step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t4_quiet_err", 32'(gray_err), 0);
        chk("t4_quiet_count", 32'(err_count), 0);
        // reset mid-stream with sync_bin=7 and a new value in flight
        unsync_gray = 4'b0100;
        repeat (4) step();
        chk("t5_bin7", 32'(sync_bin), 7);
        unsync_gray = 4'b0110;
        step();
        RST = 1'b1;
        step();
        chk_zero("t5_rst");
        RST = 1'b0; unsync_gray = 4'b0000; ups = 0;
        repeat (6) begin
            step();
            ups += int'(sync_update);
        end
        chk("t5_no_upd", ups, 0);
        chk("t5_bin0", 32'(sync_bin), 0);
        // 3-stage build, checker disabled
        RST = 1'b1;
        step();
        RST = 1'b0; unsync_gray = 4'b0001;
        step();
        step();
        step();
        chk("t6_gray_e3", 32'(sync_gray3), 1);
        chk("t6_upd_e3", 32'(sync_update3), 0);
        step();
        chk("t6_upd_e4", 32'(sync_update3), 1);
        chk("t6_bin_e4", 32'(sync_bin3), 1);
        unsync_gray = 4'b0000;
        repeat (5) step();
        unsync_gray = 4'b0011; ups = 0; errs = 0;
        repeat (6) begin
            step();
            ups += int'(sync_update3);
            errs += int'(gray_err3);
        end
        chk("t6_ups", ups, 1);
        chk("t6_errs", errs, 0);
        chk("t6_sticky", 32'(err_sticky3), 0);
        chk("t6_count", 32'(err_count3), 0);
        chk("t6_bin2", 32'(sync_bin3), 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
